cic_decimator: RTL and testbench

CIC_DECIMATOR -- requirements
Module: cic_decimator

---
 rtl/cic_decimator.sv | 127 ++++++++++++
 tb/tb_cic_decimator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator.sv
// cic_decimator: multi-stage CIC decimation filter with runtime-selectable
// power-of-two ratio and gain normalisation by arithmetic shift.
// Optional build macro CIC_DECIMATOR_ROUND_EN: round-half-up before the shift
// and saturate to the output range; when undefined the shift floors and the
// result is simply truncated to DATA_WIDTH bits.
module cic_decimator #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_STAGES     = 3,
  parameter int MAX_DECIM_LOG2 = 4,
  parameter int ACC_WIDTH      = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sync_clr,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic [2:0]                   decim_log2,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out
);

  // Integrator chain, sample-rate control and ratio of the group in progress
  logic signed [ACC_WIDTH-1:0] integ_q [NUM_STAGES];
  logic [MAX_DECIM_LOG2-1:0]   phase_q;
  logic [2:0]                  ratio_q;
  logic [2:0]                  req_log2;
  logic [2:0]                  eff_log2;
  logic [MAX_DECIM_LOG2:0]     last_phase;
  logic                        evt;

  // Decimated-rate pipeline: index 0 is the launch slot, 1..N follow each comb
  logic [NUM_STAGES:0]         vld_p;
  logic [2:0]                  lg_p   [NUM_STAGES+1];
  logic signed [ACC_WIDTH-1:0] comb_q [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] dly_q  [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] comb_in [NUM_STAGES];

  // Gain normalisation: shift by NUM_STAGES*log2(R), optional round/saturate
  function automatic logic signed [DATA_WIDTH-1:0] scale_sample(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic [2:0]                  lg
  );
    int sh;
`ifdef CIC_DECIMATOR_ROUND_EN
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] smax;
    logic signed [ACC_WIDTH:0] smin;
`endif
    sh = NUM_STAGES * int'(lg);
`ifdef CIC_DECIMATOR_ROUND_EN
    smax = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    smin = ~smax;
    ext  = (ACC_WIDTH+1)'(v);
    if (sh > 0) ext = ext + ((ACC_WIDTH+1)'(1) <<< (sh - 1));
    rnd = ext >>> sh;
    if (rnd > smax)      rnd = smax;
    else if (rnd < smin) rnd = smin;
    return rnd[DATA_WIDTH-1:0];
`else
    return DATA_WIDTH'(v >>> sh);
`endif
  endfunction

  // Event detection: the first sample of a group uses the freshly requested ratio
  always_comb begin
    req_log2   = (decim_log2 > 3'(MAX_DECIM_LOG2)) ? 3'(MAX_DECIM_LOG2) : decim_log2;
    eff_log2   = (phase_q == '0) ? req_log2 : ratio_q;
    last_phase = ({{MAX_DECIM_LOG2{1'b0}}, 1'b1} << eff_log2) - 1'b1;
    evt        = valid_in && ({1'b0, phase_q} == last_phase);
  end

  // Comb stage inputs: first comb reads the last integrator, others chain
  always_comb begin
    comb_in[0] = integ_q[NUM_STAGES-1];
    for (int k = 1; k < NUM_STAGES; k++) comb_in[k] = comb_q[k-1];
  end

  // Integrators, phase counter and ratio latch (advance only on valid_in)
  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      for (int k = 0; k < NUM_STAGES; k++) integ_q[k] <= '0;
      phase_q <= '0;
      if (rst) ratio_q <= '0;
    end else if (valid_in) begin
      integ_q[0] <= integ_q[0] + ACC_WIDTH'(data_in);
      for (int k = 1; k < NUM_STAGES; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
      if (phase_q == '0) ratio_q <= req_log2;
      phase_q <= evt ? '0 : phase_q + 1'b1;
    end
  end

  // Launch slot and comb pipeline: advances every cycle, combs update on valid
  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      vld_p <= '0;
      for (int k = 0; k <= NUM_STAGES; k++) lg_p[k] <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        comb_q[k] <= '0;
        dly_q[k]  <= '0;
      end
    end else begin
      vld_p[0] <= evt;
      lg_p[0]  <= eff_log2;
      for (int k = 0; k < NUM_STAGES; k++) begin
        vld_p[k+1] <= vld_p[k];
        lg_p[k+1]  <= lg_p[k];
        if (vld_p[k]) begin
          comb_q[k] <= comb_in[k] - dly_q[k];
          dly_q[k]  <= comb_in[k];
        end
      end
    end
  end

  // Output register: strobe for one cycle, hold data between strobes
  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= vld_p[NUM_STAGES];
      if (vld_p[NUM_STAGES]) data_out <= scale_sample(comb_q[NUM_STAGES-1], lg_p[NUM_STAGES]);
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: scoreboard bench for cic_decimator. The reference model
// keeps the accepted input samples and computes each decimated output as a
// binomial-weighted sum (integrator cascade) followed by an N-th difference
// over the decimated sequence, then normalises by the CIC gain.
module tb_cic_decimator;
  localparam int DW = 16;
  localparam int NS = 3;
  localparam int ML = 4;
  localparam int AW = 28;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sync_clr;
  logic                 valid_in;
  logic signed [DW-1:0] data_in;
  logic [2:0]           decim_log2;
  logic                 valid_out;
  logic signed [DW-1:0] data_out;

  cic_decimator #(
    .DATA_WIDTH(DW), .NUM_STAGES(NS), .MAX_DECIM_LOG2(ML), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .valid_in(valid_in),
    .data_in(data_in), .decim_log2(decim_log2),
    .valid_out(valid_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int due; int val; } exp_t;
  exp_t expq[$];

  longint xs[$];
  longint vs[$];
  int     pos   = 0;
  int     ratio = 0;
  bit     mon_en = 1'b0;
  logic signed [DW-1:0] last_out = '0;

  function automatic longint binom(input int a, input int b);
    longint r;
    if (b < 0 || a < b) return 0;
    r = 1;
    for (int i = 1; i <= b; i++) r = r * (a - b + i) / i;
    return r;
  endfunction

  function automatic int model_scale(input longint c_in, input int sh);
    longint m, c, r, hi, lo;
    m = longint'(1) << AW;
    c = c_in % m;
    if (c < 0) c += m;
    if (c >= m / 2) c -= m;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
`ifdef CIC_DECIMATOR_ROUND_EN
    if (sh > 0) c += longint'(1) << (sh - 1);
    r = c >>> sh;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    r = c >>> sh;
    r = r & ((longint'(1) << DW) - 1);
    if (r > hi) r -= longint'(1) << DW;
`endif
    return int'(r);
  endfunction

  task automatic model_step(input bit v, input int d, input int dl);
    longint s, c;
    int n, m;
    if (!v) return;
    if (pos == 0) ratio = (dl > ML) ? ML : dl;
    xs.push_back(longint'(d));
    if (pos == (1 << ratio) - 1) begin
      n = xs.size() - 1;
      s = 0;
      for (int j = 0; j <= n; j++) s += xs[j] * binom(n - j, NS - 1);
      vs.push_back(s);
      m = vs.size() - 1;
      c = 0;
      for (int k = 0; k <= NS; k++)
        if (m - k >= 0) c += ((k % 2) ? -1 : 1) * binom(NS, k) * vs[m-k];
      expq.push_back('{due: cyc + NS + 2, val: model_scale(c, NS * ratio)});
      pos = 0;
    end else begin
      pos++;
    end
  endtask

  task automatic drive(input bit v, input int d, input int dl);
    @(posedge clk); #1;
    rst = 1'b0; sync_clr = 1'b0;
    valid_in = v; data_in = DW'(d); decim_log2 = 3'(dl);
    model_step(v, d, dl);
  endtask

  task automatic do_clear(input bit use_rst);
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1; else sync_clr = 1'b1;
    valid_in = 1'b1; data_in = DW'(1234);
    while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
    xs.delete(); vs.delete(); pos = 0; ratio = 0;
    @(posedge clk); #1;
    rst = 1'b0; sync_clr = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL %s_clear: valid_out=%0b data_out=%0d, required 0/0",
               use_rst ? "rst" : "sync", valid_out, data_out);
    end
  endtask

  task automatic check_settled(input string name, input int want);
    repeat (NS + 4) drive(1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (data_out !== DW'(want)) begin
      errors++;
      $display("FAIL %s: data_out=%0d, required %0d", name, data_out, want);
    end
  endtask

  // Monitor: compare every strobe against the scoreboard, check hold otherwise
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (expq.size() > 0 && expq[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missed_strobe: no strobe in cycle %0d, required value %0d", expq[0].due, expq[0].val);
        void'(expq.pop_front());
      end
      checks++;
      if (valid_out === 1'b1) begin
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: cycle %0d data_out=%0d, required no strobe", cyc, data_out);
        end else if (expq[0].due != cyc) begin
          errors++;
          $display("FAIL strobe_timing: strobe in cycle %0d, required cycle %0d", cyc, expq[0].due);
          if (expq[0].due < cyc) void'(expq.pop_front());
        end else begin
          e = expq.pop_front();
          if (data_out !== DW'(e.val)) begin
            errors++;
            $display("FAIL data_out: cycle %0d got %0d, required %0d", cyc, data_out, e.val);
          end
        end
        last_out = data_out;
      end else if (valid_out !== 1'b0 || data_out !== last_out) begin
        errors++;
        $display("FAIL hold: cycle %0d valid_out=%0b data_out=%0d, required 0 and held %0d",
                 cyc, valid_out, data_out, last_out);
      end
      if (rst || sync_clr) last_out = '0;
    end
  end

  initial begin
    int dl;
    int d;
    rst = 1'b1; sync_clr = 1'b0; valid_in = 1'b0; data_in = '0; decim_log2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset: valid_out=%0b data_out=%0d, required 0/0", valid_out, data_out);
    end
    mon_en = 1'b1;

    // Constant unity input at R=4
    repeat (120) drive(1'b1, 1, 2);
    check_settled("const_one", 1);
    do_clear(1'b0);

    // Ramp at R=1: output every cycle
    for (int i = 0; i < 80; i++) drive(1'b1, i, 0);
    do_clear(1'b0);

    // Full-scale extremes at R=16
    repeat (200) drive(1'b1, -32768, 4);
    check_settled("neg_full_scale", -32768);
    repeat (200) drive(1'b1, 32767, 4);
    check_settled("pos_full_scale", 32767);
    do_clear(1'b0);

    // Impulse at R=2
    drive(1'b1, 4, 1);
    repeat (20) drive(1'b1, 0, 1);
    do_clear(1'b1);

    // Ratio change mid-group with random gaps
    repeat (6) drive(1'b1, int'($urandom_range(0, 2000)) - 1000, 2);
    for (int i = 0; i < 80; i++)
      drive(($urandom_range(0, 2) != 0), int'($urandom_range(0, 2000)) - 1000, 3);
    repeat (NS + 4) drive(1'b0, 0, 3);

    // Random traffic with ratio changes, clears mid-stream
    dl = 2;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 49) == 0) dl = int'($urandom_range(0, 7));
      d = int'($urandom_range(0, 65535)) - 32768;
      drive(($urandom_range(0, 3) != 0), d, dl);
      if (i == 400) do_clear(1'b0);
      if (i == 800) do_clear(1'b1);
    end

    repeat (NS + 6) drive(1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still pending, required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
